// File: rtl/race_pkg.sv
// Shared types and constants for the race timing unit.
package race_pkg;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_RUNNING,
        RS_FINISHED
    } raceState_t;

    localparam int FRAME_DIV_DEF = 833_334;
    localparam int SEC_DIV_DEF   = 49_999_999;

    // Short divider periods so simulations reach whole seconds quickly
    localparam int FRAME_DIV_SIM = 3;
    localparam int SEC_DIV_SIM   = 9;

endpackage

// File: rtl/tick_divider.sv
// Free-running down-counter that emits a one-cycle tick every RELOAD+1 cycles.
module tick_divider #(
    parameter int RELOAD = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic reload,
    output logic tick
);

    localparam int CNT_W = (RELOAD < 1) ? 1 : $clog2(RELOAD + 1);

    logic [CNT_W-1:0] count;

    // Reload on reset, on request, or after the zero cycle has been emitted
    always_ff @(posedge Clock) begin
        if (Reset || reload || count == '0)
            count <= CNT_W'(RELOAD);
        else
            count <= count - 1'b1;
    end

    assign tick = (count == '0);

endmodule

// File: rtl/race_timer.sv
// Race timing unit: frame/seconds ticks plus race, lap and best-lap tracking.
// Optional macro RACE_TIMER_BCD_EN adds a registered 3-digit BCD view of secondsPassed.
module race_timer
    import race_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEF,
    parameter int SEC_DIV   = SEC_DIV_DEF,
    parameter int SEC_W     = 8,
    parameter int NUM_LAPS  = 3,
    parameter int LAP_W     = $clog2(NUM_LAPS + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             LapCross,
    output logic             Enable1Frame,
    output logic             Enable1Second,
    output logic [SEC_W-1:0] secondsPassed,
    output logic [SEC_W-1:0] lapTime,
    output logic [SEC_W-1:0] lastLap,
    output logic [SEC_W-1:0] bestLap,
    output logic             bestValid,
    output logic [LAP_W-1:0] lapCount,
    output logic             lapStrobe,
`ifdef RACE_TIMER_BCD_EN
    output logic [11:0]      secondsBCD,
`endif
    output logic             raceDone
);

    localparam logic [SEC_W-1:0] SEC_MAX = '1;

    raceState_t       state, stateNext;
    logic [SEC_W-1:0] secondsNext, lapTimeNext, lastLapNext, bestLapNext;
    logic [SEC_W-1:0] completedLap;
    logic [LAP_W-1:0] lapCountNext;
    logic             bestValidNext, lapStrobeNext, clearAll;
    logic             secReload, raceTick;

    function automatic logic [SEC_W-1:0] satInc(input logic [SEC_W-1:0] v);
        return (v == SEC_MAX) ? v : v + 1'b1;
    endfunction

    // Restart the seconds divider as a race begins so its first second is full length
    assign secReload = (state == RS_IDLE) && Start;

    tick_divider #(.RELOAD(FRAME_DIV)) frameDiv (
        .Clock  (Clock),
        .Reset  (Reset),
        .reload (1'b0),
        .tick   (Enable1Frame)
    );

    tick_divider #(.RELOAD(SEC_DIV)) secDiv (
        .Clock  (Clock),
        .Reset  (Reset),
        .reload (secReload),
        .tick   (Enable1Second)
    );

    assign raceTick = Enable1Second && (state == RS_RUNNING);
    assign raceDone = (state == RS_FINISHED);

    always_comb begin
        stateNext     = state;
        secondsNext   = secondsPassed;
        lapTimeNext   = lapTime;
        lastLapNext   = lastLap;
        bestLapNext   = bestLap;
        bestValidNext = bestValid;
        lapCountNext  = lapCount;
        lapStrobeNext = 1'b0;
        clearAll      = 1'b0;
        completedLap  = raceTick ? satInc(lapTime) : lapTime;

        case (state)
            RS_IDLE: begin
                clearAll = 1'b1;
                if (Start)
                    stateNext = RS_RUNNING;
            end
            RS_RUNNING: begin
                if (!Start) begin
                    clearAll  = 1'b1;
                    stateNext = RS_IDLE;
                end else begin
                    if (raceTick) begin
                        secondsNext = satInc(secondsPassed);
                        lapTimeNext = satInc(lapTime);
                    end
                    if (LapCross) begin
                        lastLapNext   = completedLap;
                        lapTimeNext   = '0;
                        lapCountNext  = lapCount + 1'b1;
                        lapStrobeNext = 1'b1;
                        bestValidNext = 1'b1;
                        if (!bestValid || completedLap < bestLap)
                            bestLapNext = completedLap;
                        if (lapCountNext == LAP_W'(NUM_LAPS))
                            stateNext = RS_FINISHED;
                    end
                end
            end
            RS_FINISHED: begin
                if (!Start) begin
                    clearAll  = 1'b1;
                    stateNext = RS_IDLE;
                end
            end
            default: begin
                clearAll  = 1'b1;
                stateNext = RS_IDLE;
            end
        endcase

        if (clearAll) begin
            secondsNext   = '0;
            lapTimeNext   = '0;
            lastLapNext   = '0;
            bestLapNext   = SEC_MAX;
            bestValidNext = 1'b0;
            lapCountNext  = '0;
            lapStrobeNext = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= RS_IDLE;
            secondsPassed <= '0;
            lapTime       <= '0;
            lastLap       <= '0;
            bestLap       <= SEC_MAX;
            bestValid     <= 1'b0;
            lapCount      <= '0;
            lapStrobe     <= 1'b0;
        end else begin
            state         <= stateNext;
            secondsPassed <= secondsNext;
            lapTime       <= lapTimeNext;
            lastLap       <= lastLapNext;
            bestLap       <= bestLapNext;
            bestValid     <= bestValidNext;
            lapCount      <= lapCountNext;
            lapStrobe     <= lapStrobeNext;
        end
    end

`ifdef RACE_TIMER_BCD_EN
    logic [9:0]  binClamped;
    logic [21:0] dabble;
    logic [11:0] bcdComb;

    // Double-dabble of a value clamped to 999 so three digits always suffice
    always_comb begin
        binClamped = 10'd999;
        if (32'(secondsPassed) < 32'd1000)
            binClamped = 10'(secondsPassed);
        dabble = {12'd0, binClamped};
        for (int i = 0; i < 10; i++) begin
            if (dabble[13:10] >= 4'd5) dabble[13:10] = dabble[13:10] + 4'd3;
            if (dabble[17:14] >= 4'd5) dabble[17:14] = dabble[17:14] + 4'd3;
            if (dabble[21:18] >= 4'd5) dabble[21:18] = dabble[21:18] + 4'd3;
            dabble = dabble << 1;
        end
        bcdComb = dabble[21:10];
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            secondsBCD <= '0;
        else
            secondsBCD <= bcdComb;
    end
`endif

endmodule

// File: tb/tb_race_timer.sv
// Self-checking bench for race_timer: lap results go through a scoreboard queue.
module tb_race_timer;
    import race_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       LapCross = 1'b0;
    logic       Enable1Frame, Enable1Second, bestValid, lapStrobe, raceDone;
    logic [7:0] secondsPassed, lapTime, lastLap, bestLap;
    logic [1:0] lapCount;
`ifdef RACE_TIMER_BCD_EN
    logic [11:0] secondsBCD, secondsBCD4;
`endif

    logic       Start4 = 1'b0;
    logic       Enable1Frame4, Enable1Second4, bestValid4, lapStrobe4, raceDone4;
    logic [3:0] secondsPassed4, lapTime4, lastLap4, bestLap4;
    logic [1:0] lapCount4;

    typedef struct {
        int lastLap;
        int bestLap;
        int lapCount;
        int secs;
    } lapExp_t;

    lapExp_t sbQueue[$];
    int      vectors = 0;
    int      miscompares = 0;
    int      raceCyc = 0;
    int      dut4Cyc = 0;
    logic    dut4Run = 1'b0;

    always #5 Clock = ~Clock;

    race_timer #(
        .FRAME_DIV (FRAME_DIV_SIM),
        .SEC_DIV   (SEC_DIV_SIM),
        .SEC_W     (8),
        .NUM_LAPS  (3)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Start         (Start),
        .LapCross      (LapCross),
        .Enable1Frame  (Enable1Frame),
        .Enable1Second (Enable1Second),
        .secondsPassed (secondsPassed),
        .lapTime       (lapTime),
        .lastLap       (lastLap),
        .bestLap       (bestLap),
        .bestValid     (bestValid),
        .lapCount      (lapCount),
        .lapStrobe     (lapStrobe),
`ifdef RACE_TIMER_BCD_EN
        .secondsBCD    (secondsBCD),
`endif
        .raceDone      (raceDone)
    );

    race_timer #(
        .FRAME_DIV (FRAME_DIV_SIM),
        .SEC_DIV   (SEC_DIV_SIM),
        .SEC_W     (4),
        .NUM_LAPS  (3)
    ) dut4 (
        .Clock         (Clock),
        .Reset         (Reset),
        .Start         (Start4),
        .LapCross      (1'b0),
        .Enable1Frame  (Enable1Frame4),
        .Enable1Second (Enable1Second4),
        .secondsPassed (secondsPassed4),
        .lapTime       (lapTime4),
        .lastLap       (lastLap4),
        .bestLap       (bestLap4),
        .bestValid     (bestValid4),
        .lapCount      (lapCount4),
        .lapStrobe     (lapStrobe4),
`ifdef RACE_TIMER_BCD_EN
        .secondsBCD    (secondsBCD4),
`endif
        .raceDone      (raceDone4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic startVal, input logic lapVal);
        Start    = startVal;
        LapCross = lapVal;
    endtask

    // One clock edge, then sample; every lap strobe must match a queued expectation
    task automatic stepCycle();
        lapExp_t e;
        @(posedge Clock);
        #1;
        raceCyc++;
        if (dut4Run) dut4Cyc++;
        if (lapStrobe) begin
            if (sbQueue.size() == 0) begin
                checkOutput("spuriousStrobe", lapStrobe, 0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("lastLap", lastLap, e.lastLap);
                checkOutput("bestLap", bestLap, e.bestLap);
                checkOutput("lapCount", lapCount, e.lapCount);
                checkOutput("lapSecs", secondsPassed, e.secs);
                checkOutput("lapBestValid", bestValid, 1);
                checkOutput("lapTimeCleared", lapTime, 0);
            end
        end
        if (dut4Run && dut4Cyc == 205) begin
            checkOutput("sat4Seconds", secondsPassed4, 15);
            checkOutput("sat4LapTime", lapTime4, 15);
        end
    endtask

    task automatic runTo(input int target);
        while (raceCyc < target) stepCycle();
    endtask

    task automatic startRace();
        applyStimulus(1'b1, 1'b0);
        stepCycle();
        raceCyc = 0;
    endtask

    task automatic lapAt(input int t, input bit onTick, input int expL, input int expBest,
                         input int expCount, input int expSecs);
        lapExp_t e;
        runTo(onTick ? 10 * t - 1 : 10 * t);
        e.lastLap  = expL;
        e.bestLap  = expBest;
        e.lapCount = expCount;
        e.secs     = expSecs;
        sbQueue.push_back(e);
        applyStimulus(1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("strobeLatency", sbQueue.size(), 0);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "Secs"}, secondsPassed, 0);
        checkOutput({tag, "LapTime"}, lapTime, 0);
        checkOutput({tag, "LastLap"}, lastLap, 0);
        checkOutput({tag, "BestLap"}, bestLap, 8'hFF);
        checkOutput({tag, "BestValid"}, bestValid, 0);
        checkOutput({tag, "LapCount"}, lapCount, 0);
        checkOutput({tag, "Strobe"}, lapStrobe, 0);
        checkOutput({tag, "Done"}, raceDone, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, then idle with Start low: check divider phases cycle by cycle
        stepCycle();
        stepCycle();
        checkCleared("reset");
        Reset = 1'b0;
        for (int j = 0; j < 40; j++) begin
            checkOutput($sformatf("frameTick%0d", j), Enable1Frame, (j % 4) == 3);
            checkOutput($sformatf("secTick%0d", j), Enable1Second, (j % 10) == 9);
            stepCycle();
        end
        checkCleared("idle");

        // Race 1: three laps at 3 s, 8 s and 10 s; the 4-bit instance starts alongside
        Start4  = 1'b1;
        dut4Run = 1'b1;
        dut4Cyc = -1;
        startRace();
        lapAt(3, 1'b0, 3, 3, 1, 3);
        runTo(80);
        checkOutput("lap2Running", lapTime, 5);
        lapAt(8, 1'b0, 5, 3, 2, 8);
        lapAt(10, 1'b0, 2, 2, 3, 10);
        checkOutput("doneAfterLap3", raceDone, 1);
        runTo(104);
        applyStimulus(1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 1'b0);
        runTo(125);
        checkOutput("frozenSecs", secondsPassed, 10);
        checkOutput("frozenLapTime", lapTime, 0);
        checkOutput("frozenCount", lapCount, 3);
        checkOutput("frozenBest", bestLap, 2);
        checkOutput("frozenDone", raceDone, 1);

        applyStimulus(1'b0, 1'b0);
        stepCycle();
        checkCleared("finishAbort");

        // Race 2: lap coincident with a race tick, then abort with LapCross held
        startRace();
        runTo(40);
        checkOutput("preTickLapTime", lapTime, 4);
        lapAt(5, 1'b1, 5, 5, 1, 5);
        runTo(63);
        applyStimulus(1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        checkCleared("midAbort");
        for (int k = 0; k < 25; k++) stepCycle();
        checkOutput("idleHoldSecs", secondsPassed, 0);
        checkOutput("idleHoldDone", raceDone, 0);

        // Race 3: long run to 137 s with no laps
        startRace();
        runTo(1370);
        checkOutput("longSecs", secondsPassed, 137);
        checkOutput("longLapTime", lapTime, 137);
        stepCycle();
`ifdef RACE_TIMER_BCD_EN
        checkOutput("bcd137", secondsBCD, 12'h137);
`endif
        checkOutput("longCount", lapCount, 0);
        checkOutput("queueEmpty", sbQueue.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
